bram_stress_array: RTL and testbench

Parametrised BRAM power/stress array: NUM_INST independent inferred-BRAM lanes, each running identical write-then-readback pattern sweeps under one shared sequencer. It generalises the fixed-count BRAM power-test array with several additions: configurable data width, depth, iteration count and pattern mode; per-group lane gating for toggle-rate/power sweeps; and an aggregated failure count. It sits at the top of the power-analysis test designs, driven by board-level start/enable controls and reporting pass/fail to LEDs or debug cores.

---
 rtl/bram_stress_pkg.sv | 43 ++++
 rtl/bram_stress_lane.sv | 61 ++++++
 rtl/bram_stress_array.sv | 162 ++++++++++++++++
 tb/tb_bram_stress_array.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_stress_pkg.sv
// Shared types and helpers for the BRAM stress array: sequencer states, pattern modes,
// the pattern generator and the failure-count width helper.
package bram_stress_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StCheck,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ModeAddr    = 2'd0,
    ModeChecker = 2'd1,
    ModeInvAddr = 2'd2,
    ModeSolid   = 2'd3
  } mode_e;

  // Patterns are built at this width and truncated by the lane, so DATA_W must not exceed it.
  localparam int unsigned PatW = 64;

  function automatic logic [PatW-1:0] pat(input logic [1:0] mode, input logic [PatW-1:0] addr,
                                          input logic iter0, input int unsigned id);
    logic [PatW-1:0] sum;
    logic [PatW-1:0] res;
    sum = addr + PatW'(id);
    res = '0;
    unique case (mode_e'(mode))
      ModeAddr:    res = sum;
      ModeChecker: res = (addr[0] ^ iter0) ? {32{2'b01}} : {32{2'b10}};
      ModeInvAddr: res = ~sum;
      ModeSolid:   res = iter0 ? '1 : '0;
      default:     res = '0;
    endcase
    return res;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bram_stress_lane.sv
// One stress lane: inferred simple-dual-port RAM with registered read, plus the
// readback compare and a sticky error flag.
module bram_stress_lane
  import bram_stress_pkg::*;
#(
  parameter int unsigned ID     = 0,
  parameter int unsigned DATA_W = 36,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              lane_en,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic              iter0,
  input  logic [1:0]        mode,
  input  logic              chk_valid,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic              chk_iter0,
  input  logic              flip,
  output logic              err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] expect_data;
  logic              ram_we;
  logic              ram_re;
  logic              mismatch;

  // Disabled lanes never touch their RAM, so they contribute no switching activity.
  assign ram_we = we & lane_en;
  assign ram_re = re & lane_en;

  assign wdata       = DATA_W'(pat(mode, PatW'(addr), iter0, ID)) ^ DATA_W'(flip);
  assign expect_data = DATA_W'(pat(mode, PatW'(chk_addr), chk_iter0, ID));
  assign mismatch    = chk_valid & lane_en & (dout != expect_data);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[addr] <= wdata;
    end
    if (ram_re) begin
      dout <= mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err <= 1'b0;
    end else if (mismatch) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/bram_stress_array.sv
// BRAM stress array top: shared write/read/check sequencer, per-group lane gating and
// failure reduction. Optional feature: BRAM_STRESS_ERR_INJECT_EN adds the inject_err port.
module bram_stress_array
  import bram_stress_pkg::*;
#(
  parameter int unsigned NUM_INST   = 40,
  parameter int unsigned DATA_W     = 36,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned ITERS      = 4,
  parameter int unsigned NUM_GROUPS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dut_start,
  input  logic                          dut_enable,
  input  logic [1:0]                    mode,
  input  logic [NUM_GROUPS-1:0]         group_en,
`ifdef BRAM_STRESS_ERR_INJECT_EN
  input  logic                          inject_err,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [cnt_w(NUM_INST)-1:0]    fail_count
);

  localparam int unsigned CW = cnt_w(NUM_INST);
  localparam int unsigned IW = (ITERS > 1) ? $clog2(ITERS) : 1;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [IW-1:0]         iter_q, iter_d;
  logic [1:0]            mode_q;
  logic [NUM_GROUPS-1:0] gen_q;
  logic                  rd_valid_q;
  logic [ADDR_W-1:0]     rd_addr_q;
  logic                  rd_iter0_q;
  logic [CW-1:0]         fail_cnt_q;
  logic [CW-1:0]         live_cnt;
  logic                  start_acc;
  logic                  we, re;
  logic                  inj_flip;
  logic [NUM_INST-1:0]   lane_en;
  logic [NUM_INST-1:0]   err;

  assign start_acc = dut_start & ((state_q == StIdle) | (state_q == StDone));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    iter_d  = iter_q;
    we      = 1'b0;
    re      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (dut_start) begin
          state_d = StWrite;
          addr_d  = '0;
          iter_d  = '0;
        end
      end
      StWrite: begin
        if (dut_enable) begin
          we     = 1'b1;
          addr_d = addr_q + 1'b1;
          if (addr_q == '1) state_d = StRead;
        end
      end
      StRead: begin
        if (dut_enable) begin
          re     = 1'b1;
          addr_d = addr_q + 1'b1;
          if (addr_q == '1) state_d = StCheck;
        end
      end
      StCheck: begin
        if (dut_enable) begin
          if (iter_q == IW'(ITERS - 1)) begin
            state_d = StDone;
          end else begin
            iter_d  = iter_q + 1'b1;
            state_d = StWrite;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      iter_q     <= '0;
      mode_q     <= '0;
      gen_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_iter0_q <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      iter_q     <= iter_d;
      // The compare trails the RAM read by one cycle, independent of stalls.
      rd_valid_q <= re;
      rd_addr_q  <= addr_q;
      rd_iter0_q <= iter_q[0];
      if (start_acc) begin
        mode_q <= mode;
        gen_q  <= group_en;
      end
      if (state_q == StDone) begin
        fail_cnt_q <= live_cnt;
      end
    end
  end

`ifdef BRAM_STRESS_ERR_INJECT_EN
  assign inj_flip = inject_err & we;
`else
  assign inj_flip = 1'b0;
`endif

  for (genvar k = 0; k < NUM_INST; k++) begin : g_lane
    assign lane_en[k] = gen_q[k % NUM_GROUPS];

    bram_stress_lane #(
      .ID     (k),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .clr       (start_acc),
      .lane_en   (lane_en[k]),
      .we        (we),
      .re        (re),
      .addr      (addr_q),
      .iter0     (iter_q[0]),
      .mode      (mode_q),
      .chk_valid (rd_valid_q),
      .chk_addr  (rd_addr_q),
      .chk_iter0 (rd_iter0_q),
      .flip      ((k == 0) ? inj_flip : 1'b0),
      .err       (err[k])
    );
  end

  always_comb begin
    live_cnt = '0;
    for (int k = 0; k < NUM_INST; k++) begin
      live_cnt = live_cnt + CW'(err[k] & lane_en[k]);
    end
  end

  assign busy       = (state_q == StWrite) | (state_q == StRead) | (state_q == StCheck);
  assign done       = (state_q == StDone);
  assign fail_count = done ? live_cnt : fail_cnt_q;
  assign pass       = done & (live_cnt == '0);

endmodule

// File: tb/tb_bram_stress_array.sv
// Directed bench for bram_stress_array at a small configuration (4 lanes, 8x16 RAMs, 2 iters).
module tb_bram_stress_array;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dut_start = 1'b0;
  logic       dut_enable = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [1:0] group_en = 2'b11;
  logic       inject_err = 1'b0;
  logic       busy, done, pass;
  logic [2:0] fail_count;

  int total = 0;
  int bad = 0;

  logic [3:0] act;
  logic       act_clr = 1'b0;

  always #5 clk = ~clk;

  bram_stress_array #(
    .NUM_INST   (4),
    .DATA_W     (8),
    .ADDR_W     (4),
    .ITERS      (2),
    .NUM_GROUPS (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dut_start  (dut_start),
    .dut_enable (dut_enable),
    .mode       (mode),
    .group_en   (group_en),
`ifdef BRAM_STRESS_ERR_INJECT_EN
    .inject_err (inject_err),
`endif
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count)
  );

  // Records which lanes ever asserted a RAM enable since the last clear.
  always @(posedge clk) begin
    if (act_clr) begin
      act <= 4'b0;
    end else begin
      act <= act | {dut.g_lane[3].u_lane.ram_we | dut.g_lane[3].u_lane.ram_re,
                    dut.g_lane[2].u_lane.ram_we | dut.g_lane[2].u_lane.ram_re,
                    dut.g_lane[1].u_lane.ram_we | dut.g_lane[1].u_lane.ram_re,
                    dut.g_lane[0].u_lane.ram_we | dut.g_lane[0].u_lane.ram_re};
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dut_start = 1'b0;
    dut_enable = 1'b1;
    inject_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle 0 is the cycle in which dut_start is driven high; returns the first cycle with done=1.
  task automatic do_run(input logic [1:0] m, input logic [1:0] ge, input int st_at,
                        input int st_len, input int pulse_at, input int inj_at,
                        output int cyc);
    int n;
    @(negedge clk);
    act_clr = 1'b1;
    @(negedge clk);
    act_clr = 1'b0;
    mode = m;
    group_en = ge;
    dut_start = 1'b1;
    dut_enable = 1'b1;
    n = 0;
    cyc = -1;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("busy_c1", 32'(busy), 32'd1);
        chk("done_c1", 32'(done), 32'd0);
      end
      if (done) begin
        cyc = n;
        break;
      end
      dut_start  = (n == pulse_at);
      dut_enable = !((st_len > 0) && (n >= st_at) && (n < st_at + st_len));
      inject_err = (n == inj_at);
    end
    dut_start = 1'b0;
    dut_enable = 1'b1;
    inject_err = 1'b0;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [1:0] ge;
    int         st_at;
    int         st_len;
    int         exp_cyc;
    logic       exp_pass;
    int         exp_fail;
    logic [3:0] exp_act;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc;
    logic p_s;
    logic [2:0] f_s;

    vecs[0] = '{2'd0, 2'b11, 0, 0,  67, 1'b1, 0, 4'b1111};
    vecs[1] = '{2'd0, 2'b11, 5, 10, 77, 1'b1, 0, 4'b1111};
    vecs[2] = '{2'd1, 2'b11, 0, 0,  67, 1'b1, 0, 4'b1111};
    vecs[3] = '{2'd2, 2'b11, 0, 0,  67, 1'b1, 0, 4'b1111};
    vecs[4] = '{2'd3, 2'b10, 0, 0,  67, 1'b1, 0, 4'b1010};
    vecs[5] = '{2'd0, 2'b01, 0, 0,  67, 1'b1, 0, 4'b0101};

    do_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail_count", 32'(fail_count), 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      do_run(vecs[i].mode, vecs[i].ge, vecs[i].st_at, vecs[i].st_len, -1, -1, cyc);
      chk($sformatf("v%0d_done_cycle", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].exp_pass));
      chk($sformatf("v%0d_fail_count", i), 32'(fail_count), 32'(vecs[i].exp_fail));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
      p_s = pass;
      f_s = fail_count;
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_done_hold", i), 32'(done), 32'd1);
      chk($sformatf("v%0d_pass_hold", i), 32'(pass), 32'(p_s));
      chk($sformatf("v%0d_fail_hold", i), 32'(fail_count), 32'(f_s));
      chk($sformatf("v%0d_ram_activity", i), 32'(act), 32'(vecs[i].exp_act));
    end

    // Restart straight from DONE without reset.
    do_run(2'd2, 2'b11, 0, 0, -1, -1, cyc);
    chk("restart_done_cycle", 32'(cyc), 32'd67);
    chk("restart_pass", 32'(pass), 32'd1);

    // Start pulsed while busy must not restart the run.
    do_reset();
    do_run(2'd0, 2'b11, 0, 0, 10, -1, cyc);
    chk("busy_start_done_cycle", 32'(cyc), 32'd67);
    chk("busy_start_pass", 32'(pass), 32'd1);

    // Reset during READ (cycle 20), then a fresh mode-1 run.
    do_reset();
    @(negedge clk);
    mode = 2'd0;
    group_en = 2'b11;
    dut_start = 1'b1;
    @(negedge clk);
    dut_start = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_pass", 32'(pass), 32'd0);
    rst = 1'b0;
    do_run(2'd1, 2'b11, 0, 0, -1, -1, cyc);
    chk("after_rst_done_cycle", 32'(cyc), 32'd67);
    chk("after_rst_pass", 32'(pass), 32'd1);

`ifdef BRAM_STRESS_ERR_INJECT_EN
    // Cycle 6 is iter 0, WRITE addr 5.
    do_reset();
    do_run(2'd0, 2'b11, 0, 0, -1, 6, cyc);
    chk("inj_done_cycle", 32'(cyc), 32'd67);
    chk("inj_pass", 32'(pass), 32'd0);
    chk("inj_fail_count", 32'(fail_count), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
